arb_grant_mux: RTL

Downstream stage of the round-robin arbiter. It takes the arbiter's one-hot grant vector and locks the shared output channel to the granted requester for one complete burst. While locked, it forwards that requester's valid/ready data stream through a 2-entry output buffer. It releases the lock on the burst's last beat or when a beat-count limit is reached, then waits for the next grant.

---
 rtl/arb_grant_mux_pkg.sv | 18 +
 rtl/arb_grant_mux_if.sv | 24 ++
 rtl/arb_grant_mux_skid_fifo2.sv | 34 +++
 rtl/arb_grant_mux.sv | 60 ++++++
 4 files changed

// File: rtl/arb_grant_mux_pkg.sv
// arb_pkg: shared FSM state, source index type and grant decoding helper for arb_grant_mux
package arb_pkg;
   typedef enum logic {IDLE, LOCKED} state_t;
   localparam int MaxReq = 32;
   typedef logic [$clog2(MaxReq)-1:0] src_idx_t;
   typedef struct packed {
      logic     is_onehot;
      src_idx_t index;
   } onehot_t;
   function automatic onehot_t onehot_check(input logic [MaxReq-1:0] v);
      onehot_t r;
      r.is_onehot = (v != '0) && ((v & (v - MaxReq'(1))) == '0);
      r.index = '0;
      for (int i = 0; i < MaxReq; i++)
         if (v[i]) r.index = src_idx_t'(i);
      return r;
   endfunction
endpackage

// File: rtl/arb_grant_mux_if.sv
// arb_grant_mux_if: grant, per-requester streams, output channel and status of the grant mux
interface arb_grant_mux_if #(parameter int NumReq = 3, parameter int DataW = 32);
   logic [NumReq-1:0]             grant_in;
   logic [NumReq-1:0]             req_valid;
   logic [NumReq-1:0][DataW-1:0]  req_data;
   logic [NumReq-1:0]             req_last;
   logic [NumReq-1:0]             req_ready;
   logic                          out_valid;
   logic [DataW-1:0]              out_data;
   logic                          out_last;
   logic [$clog2(NumReq)-1:0]     out_src;
   logic                          out_ready;
   logic                          busy;
   logic                          err_multi;
   logic                          err_long;
   modport master (
      output grant_in, req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_last, out_src, busy, err_multi, err_long
   );
   modport slave (
      input  grant_in, req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_last, out_src, busy, err_multi, err_long
   );
endinterface

// File: rtl/arb_grant_mux_skid_fifo2.sv
// skid_fifo2: two-entry register FIFO; output always comes straight from a storage register
module skid_fifo2 #(parameter int Width = 8) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);
   logic [Width-1:0] mem [2];
   logic wp, rp, do_push, do_pop;
   assign full = count == 2'd2;
   assign empty = count == 2'd0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rp];
   always_ff @(posedge clk)
      if (!rstN) begin
         mem <= '{default: '0};
         wp <= 1'b0;
         rp <= 1'b0;
         count <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp <= ~wp;
         end
         if (do_pop) rp <= ~rp;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
endmodule

// File: rtl/arb_grant_mux.sv
// arb_grant_mux: locks the shared output channel to the granted requester for one burst
module arb_grant_mux import arb_pkg::*; #(
   parameter int NumReq = 3,
   parameter int DataW = 32,
   parameter int MaxBeats = 16
) (
   input logic clk,
   input logic rstN,
   arb_grant_mux_if.slave bus
);
   localparam int SW = $clog2(NumReq);
   localparam int CW = $clog2(MaxBeats + 1);
   localparam int EW = DataW + 1 + SW;
   state_t state_q, state_d;
   logic [SW-1:0] src_q, grant_idx;
   logic [CW-1:0] beat_cnt;
   onehot_t oh;
   logic lock, can_push, accept, last_eff, full, empty;
   logic [1:0] fifo_count;
   logic [EW-1:0] fifo_in, fifo_out;
   assign oh = onehot_check(MaxReq'(bus.grant_in));
   assign grant_idx = SW'(oh.index);
   assign lock = state_q == IDLE && oh.is_onehot && bus.req_valid[grant_idx];
   assign can_push = state_q == LOCKED && fifo_count < 2'd2;
   assign accept = can_push && bus.req_valid[src_q];
   // a burst reaching the beat limit is closed as if the requester had flagged last
   assign last_eff = bus.req_last[src_q] || beat_cnt == CW'(MaxBeats - 1);
   assign fifo_in = {bus.req_data[src_q], last_eff, src_q};
   assign bus.req_ready = can_push ? NumReq'(1) << src_q : '0;
   assign bus.out_valid = !empty;
   assign {bus.out_data, bus.out_last, bus.out_src} = fifo_out;
   assign bus.busy = state_q == LOCKED;
   always_comb state_d = lock ? LOCKED : (accept && last_eff) ? IDLE : state_q;
   always_ff @(posedge clk) state_q <= !rstN ? IDLE : state_d;
   always_ff @(posedge clk)
      if (!rstN) begin
         src_q <= '0;
         beat_cnt <= '0;
         bus.err_multi <= 1'b0;
         bus.err_long <= 1'b0;
      end else begin
         if (lock) begin
            src_q <= grant_idx;
            beat_cnt <= '0;
         end else if (accept) beat_cnt <= beat_cnt + CW'(1);
         if (state_q == IDLE && |bus.grant_in && !oh.is_onehot) bus.err_multi <= 1'b1;
         if (accept && last_eff && !bus.req_last[src_q]) bus.err_long <= 1'b1;
      end
   skid_fifo2 #(.Width(EW)) u_fifo (
      .clk  (clk),
      .rstN (rstN),
      .push (accept && !full),
      .pop  (bus.out_valid && bus.out_ready),
      .din  (fifo_in),
      .dout (fifo_out),
      .full (full),
      .empty(empty),
      .count(fifo_count)
   );
endmodule
